// File: rtl/ofdm_periodic_framer.sv
// ofdm_periodic_framer
// Sits between the Schmidl-Cox timing block and the FFT. After an accepted
// trigger it drops a programmable offset. It then forwards frame_len-sample
// frames terminated by tlast. Between frames it strips gap_len samples of
// cyclic prefix. This repeats for max_frames frames. Settings are held in
// shadow registers and copied to the active set only when a trigger is
// accepted.
module ofdm_periodic_framer #(
  parameter int WIDTH   = 32,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 8,
  parameter int SR_BASE = 130
) (
  input  logic             ce_clk,
  input  logic             ce_rst_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tuser,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFSET = 2'd1,
    FRAME  = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [7:0]       ADDR_FRAME_LEN  = 8'(SR_BASE);
  localparam logic [7:0]       ADDR_GAP_LEN    = 8'(SR_BASE + 1);
  localparam logic [7:0]       ADDR_OFFSET     = 8'(SR_BASE + 2);
  localparam logic [7:0]       ADDR_MAX_FRAMES = 8'(SR_BASE + 3);
  localparam logic [LEN_W-1:0] LEN_ZERO        = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE         = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO        = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);

  state_t             state_r;
  logic [LEN_W-1:0]   frame_len_sh_r, gap_len_sh_r, offset_sh_r;
  logic [CNT_W-1:0]   max_frames_sh_r;
  logic [LEN_W-1:0]   frame_len_r, gap_len_r, offset_r;
  logic [CNT_W-1:0]   max_frames_r;
  logic [LEN_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   frame_idx_r;
  logic               busy_r;
  logic [WIDTH-1:0]   o_tdata_r;
  logic               o_tlast_r;
  logic               o_tvalid_r;

  logic               in_ready_s;
  logic               consume_s;
  logic               trig_s;
  logic               fwd_s;
  logic               fwd_last_s;
  logic               done_s;
  logic [LEN_W-1:0]   cur_len_s;
  logic [LEN_W-1:0]   cur_gap_s;
  logic [LEN_W-1:0]   cur_pos_s;
  logic [CNT_W-1:0]   cur_max_s;
  logic [CNT_W-1:0]   cur_idx_s;
  state_t             eof_state_s;
  logic               unused_set_data_s;

  // Upper settings bits carry no register content.
  assign unused_set_data_s = ^set_data[31:LEN_W];

  assign i_tready  = in_ready_s;
  assign consume_s = i_tvalid && in_ready_s;
  assign o_tdata   = o_tdata_r;
  assign o_tlast   = o_tlast_r;
  assign o_tvalid  = o_tvalid_r;
  assign busy      = busy_r;
  assign frame_idx = frame_idx_r;

  // Input ready: only FRAME applies backpressure; other states drop samples.
  always_comb begin
    in_ready_s = 1'b1;
    if (state_r == FRAME) begin
      in_ready_s = !o_tvalid_r || o_tready;
    end else begin
      in_ready_s = 1'b1;
    end
  end

  // Trigger/forward decode; on a trigger the shadow set is the one in force.
  always_comb begin
    trig_s = (state_r == IDLE) && consume_s && i_tuser &&
             (frame_len_sh_r != LEN_ZERO) && (max_frames_sh_r != CNT_ZERO);
    if (trig_s) begin
      cur_len_s = frame_len_sh_r;
      cur_gap_s = gap_len_sh_r;
      cur_max_s = max_frames_sh_r;
      cur_idx_s = CNT_ZERO;
      cur_pos_s = LEN_ZERO;
    end else begin
      cur_len_s = frame_len_r;
      cur_gap_s = gap_len_r;
      cur_max_s = max_frames_r;
      cur_idx_s = frame_idx_r;
      cur_pos_s = cnt_r;
    end
    fwd_s      = ((state_r == FRAME) && consume_s) || (trig_s && (offset_sh_r == LEN_ZERO));
    fwd_last_s = fwd_s && (cur_pos_s == (cur_len_s - LEN_ONE));
    done_s     = fwd_last_s && ((cur_idx_s + CNT_ONE) == cur_max_s);
    if (done_s) begin
      eof_state_s = IDLE;
    end else if (cur_gap_s == LEN_ZERO) begin
      eof_state_s = FRAME;
    end else begin
      eof_state_s = GAP;
    end
  end

  // Shadow settings registers written from the settings bus.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      frame_len_sh_r  <= LEN_W'(64);
      gap_len_sh_r    <= LEN_W'(16);
      offset_sh_r     <= LEN_ZERO;
      max_frames_sh_r <= CNT_ONE;
    end else if (set_stb) begin
      case (set_addr)
        ADDR_FRAME_LEN:  frame_len_sh_r  <= set_data[LEN_W-1:0];
        ADDR_GAP_LEN:    gap_len_sh_r    <= set_data[LEN_W-1:0];
        ADDR_OFFSET:     offset_sh_r     <= set_data[LEN_W-1:0];
        ADDR_MAX_FRAMES: max_frames_sh_r <= set_data[CNT_W-1:0];
        default:         frame_len_sh_r  <= frame_len_sh_r;
      endcase
    end else begin
      frame_len_sh_r <= frame_len_sh_r;
    end
  end

  // Main sequencing FSM: offset drop, frame forwarding, gap strip.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_r      <= IDLE;
      frame_len_r  <= LEN_ZERO;
      gap_len_r    <= LEN_ZERO;
      offset_r     <= LEN_ZERO;
      max_frames_r <= CNT_ZERO;
      cnt_r        <= LEN_ZERO;
      frame_idx_r  <= CNT_ZERO;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (trig_s) begin
            frame_len_r  <= frame_len_sh_r;
            gap_len_r    <= gap_len_sh_r;
            offset_r     <= offset_sh_r;
            max_frames_r <= max_frames_sh_r;
            frame_idx_r  <= CNT_ZERO;
            if (offset_sh_r == LEN_ZERO) begin
              // Trigger sample is frame sample 0 (may also be the last one).
              if (fwd_last_s) begin
                state_r     <= eof_state_s;
                cnt_r       <= LEN_ZERO;
                busy_r      <= !done_s;
                frame_idx_r <= done_s ? CNT_ZERO : CNT_ONE;
              end else begin
                state_r <= FRAME;
                cnt_r   <= LEN_ONE;
                busy_r  <= 1'b1;
              end
            end else if (offset_sh_r == LEN_ONE) begin
              // The trigger itself was the only sample to drop.
              state_r <= FRAME;
              cnt_r   <= LEN_ZERO;
              busy_r  <= 1'b1;
            end else begin
              state_r <= OFFSET;
              cnt_r   <= LEN_ONE;
              busy_r  <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        OFFSET: begin
          if (consume_s) begin
            if (cnt_r == (offset_r - LEN_ONE)) begin
              state_r <= FRAME;
              cnt_r   <= LEN_ZERO;
            end else begin
              cnt_r <= cnt_r + LEN_ONE;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        FRAME: begin
          if (consume_s) begin
            if (fwd_last_s) begin
              state_r <= eof_state_s;
              cnt_r   <= LEN_ZERO;
              busy_r  <= !done_s;
              if (!done_s) begin
                frame_idx_r <= frame_idx_r + CNT_ONE;
              end else begin
                frame_idx_r <= frame_idx_r;
              end
            end else begin
              cnt_r <= cnt_r + LEN_ONE;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        GAP: begin
          if (consume_s) begin
            if (cnt_r == (gap_len_r - LEN_ONE)) begin
              state_r <= FRAME;
              cnt_r   <= LEN_ZERO;
            end else begin
              cnt_r <= cnt_r + LEN_ONE;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= LEN_ZERO;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output register stage: load on forward, clear valid once drained.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      o_tdata_r  <= {WIDTH{1'b0}};
      o_tlast_r  <= 1'b0;
      o_tvalid_r <= 1'b0;
    end else if (fwd_s) begin
      o_tdata_r  <= i_tdata;
      o_tlast_r  <= fwd_last_s;
      o_tvalid_r <= 1'b1;
    end else if (o_tready) begin
      o_tvalid_r <= 1'b0;
    end else begin
      o_tvalid_r <= o_tvalid_r;
    end
  end

endmodule

// File: tb/tb_ofdm_periodic_framer.sv
// Scoreboard bench for ofdm_periodic_framer: a ramp is streamed in, the
// expected frames are queued from the programmed settings and compared as
// the output handshakes complete.
module tb_ofdm_periodic_framer;

  logic        ce_clk = 1'b0;
  logic        ce_rst_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [31:0] i_tdata = 32'd0;
  logic        i_tuser = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        busy;
  logic [7:0]  frame_idx;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  bit          trig_mask[0:4095];
  int          v = 0;
  bit          rand_rdy = 1'b0;
  bit          gaps = 1'b0;
  bit          nov = 1'b0;
  bit          wstb = 1'b0;
  logic [7:0]  waddr = 8'd0;
  logic [31:0] wdata = 32'd0;
  bit          stall_prev = 1'b0;
  logic [31:0] held_data = 32'd0;
  logic        held_last = 1'b0;
  int          out_cnt = 0;

  ofdm_periodic_framer dut (
    .ce_clk   (ce_clk),
    .ce_rst_n (ce_rst_n),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i_tdata  (i_tdata),
    .i_tuser  (i_tuser),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .busy     (busy),
    .frame_idx(frame_idx)
  );

  always #5 ce_clk = ~ce_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int start, input int len, input int gap, input int nfr);
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back({(i == len - 1), 32'(start + f * (len + gap) + i)});
      end
    end
  endtask

  // One clock: drive at the falling edge, observe handshakes 1 ns later.
  task automatic step();
    logic [32:0] e;
    @(negedge ce_clk);
    o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    i_tvalid = nov ? 1'b0 : (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
    i_tdata  = 32'(v);
    i_tuser  = trig_mask[v];
    set_stb  = wstb;
    set_addr = waddr;
    set_data = wdata;
    #1;
    if (stall_prev) begin
      check_val("stall_data", o_tdata, held_data);
      check_val("stall_last", 32'(o_tlast), 32'(held_last));
    end
    if (o_tvalid && o_tready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check_val("extra_output", 32'(o_tvalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("data", o_tdata, e[31:0]);
        check_val("last", 32'(o_tlast), 32'(e[32]));
      end
    end
    stall_prev = o_tvalid && !o_tready;
    held_data  = o_tdata;
    held_last  = o_tlast;
    if (i_tvalid && i_tready) v++;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    wstb = 1'b1; waddr = a; wdata = d; nov = 1'b1;
    step();
    wstb = 1'b0; nov = 1'b0;
  endtask

  task automatic prog(input int fl, input int gl, input int off, input int mf);
    write_reg(8'd130, 32'(fl));
    write_reg(8'd131, 32'(gl));
    write_reg(8'd132, 32'(off));
    write_reg(8'd133, 32'(mf));
    write_reg(8'd134, 32'hDEAD_BEEF);
  endtask

  task automatic new_test();
    v = 0;
    for (int i = 0; i < 4096; i++) trig_mask[i] = 1'b0;
  endtask

  task automatic run_until(input int vend, input int budget);
    int n = 0;
    while (v < vend && n < budget) begin
      step();
      n++;
    end
    check_val("stream_progress", 32'(v), 32'(vend));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) trig_mask[i] = 1'b0;
    repeat (3) @(negedge ce_clk);
    #1;
    check_val("rst_tvalid", 32'(o_tvalid), 32'd0);
    check_val("rst_tlast", 32'(o_tlast), 32'd0);
    check_val("rst_tdata", o_tdata, 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_frame_idx", 32'(frame_idx), 32'd0);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;

    // 12 frames of 64 after a 22-sample offset; retrigger at 300 ignored,
    // a new burst from the trigger at 1000.
    prog(64, 16, 22, 12);
    new_test();
    trig_mask[0] = 1'b1; trig_mask[300] = 1'b1; trig_mask[1000] = 1'b1;
    push_burst(22, 64, 16, 12);
    push_burst(1022, 64, 16, 12);
    out_cnt = 0;
    run_until(100, 400);
    check_val("t1_busy_mid", 32'(busy), 32'd1);
    check_val("t1_idx_mid", 32'(frame_idx), 32'd1);
    run_until(980, 2000);
    check_val("t1_busy_end", 32'(busy), 32'd0);
    check_val("t1_idx_end", 32'(frame_idx), 32'd11);
    run_until(1970, 2000);
    drain();
    check_val("t1_out_count", 32'(out_cnt), 32'd1536);

    // Zero offset and gap, two frames, trigger on sample 5.
    prog(64, 0, 0, 2);
    new_test();
    trig_mask[5] = 1'b1;
    push_burst(5, 64, 0, 2);
    run_until(200, 400);
    drain();
    check_val("t2_idx", 32'(frame_idx), 32'd1);
    check_val("t2_busy", 32'(busy), 32'd0);

    // Random backpressure and input gaps.
    prog(64, 16, 22, 12);
    new_test();
    trig_mask[0] = 1'b1;
    push_burst(22, 64, 16, 12);
    rand_rdy = 1'b1; gaps = 1'b1;
    run_until(980, 20000);
    drain();
    rand_rdy = 1'b0; gaps = 1'b0;
    check_val("t3_busy", 32'(busy), 32'd0);
    check_val("t3_idx", 32'(frame_idx), 32'd11);

    // Mid-burst frame_len write only applies to the next burst.
    prog(64, 16, 0, 2);
    new_test();
    trig_mask[0] = 1'b1; trig_mask[200] = 1'b1;
    push_burst(0, 64, 16, 2);
    push_burst(200, 32, 16, 2);
    run_until(30, 100);
    write_reg(8'd130, 32'd32);
    check_val("t5_busy_mid", 32'(busy), 32'd1);
    run_until(300, 600);
    drain();
    check_val("t5_idx", 32'(frame_idx), 32'd1);
    write_reg(8'd130, 32'd0);
    trig_mask[310] = 1'b1;
    run_until(320, 100);
    check_val("t5_len0_busy", 32'(busy), 32'd0);
    write_reg(8'd130, 32'd64);
    write_reg(8'd133, 32'd0);
    trig_mask[330] = 1'b1;
    run_until(340, 100);
    check_val("t5_max0_busy", 32'(busy), 32'd0);
    check_val("t5_max0_idx", 32'(frame_idx), 32'd1);

    // Reset in the middle of a frame, then defaults apply.
    prog(64, 16, 22, 12);
    new_test();
    trig_mask[0] = 1'b1;
    push_burst(22, 64, 16, 12);
    run_until(41, 200);
    @(negedge ce_clk);
    ce_rst_n = 1'b0;
    #1;
    check_val("t6_rst_tvalid", 32'(o_tvalid), 32'd0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_idx", 32'(frame_idx), 32'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    new_test();
    trig_mask[0] = 1'b1;
    push_burst(0, 64, 16, 1);
    run_until(100, 300);
    drain();
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_idx", 32'(frame_idx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
